// File: rtl/qkd_sift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qkd_sift_pkg
//  Purpose  : Shared definitions for the QKD sifting round controller:
//             round state encoding, default key-address width and the QBER
//             percentage scale used by the acceptance compare.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package qkd_sift_pkg;

    localparam int ADDR_W_DEFAULT = 10;   // sifted-key count / readout address
    localparam int PCT_SCALE      = 100;  // QBER threshold is given in percent
    localparam int QBER_PROD_W    = 17;   // width of both QBER compare products
    localparam int THRESH_W       = 7;    // 0..100 percent

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_EVAL    = 3'd3,
        S_READOUT = 3'd4,
        S_FINISH  = 3'd5,
        S_ABORT   = 3'd6
    } sift_state_e;

endpackage : qkd_sift_pkg
`default_nettype wire

// File: rtl/qkd_qber_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : qkd_qber_cmp
//  Purpose  : Combinational QBER acceptance test. The round is acceptable
//             when err_count*100 <= sift_count*qber_thresh, which avoids a
//             divider. Both products are formed as 17-bit unsigned values.
//  Ports    : sift_count  in  ADDR_W  bits sifted this round
//             err_count   in  ADDR_W  mismatched bits this round
//             qber_thresh in  7       acceptance limit in percent
//             accept      out 1       QBER within limit
//  Revision : 1.0  initial release
// ============================================================================
module qkd_qber_cmp
    import qkd_sift_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ADDR_W-1:0]   sift_count,
    input  logic [ADDR_W-1:0]   err_count,
    input  logic [THRESH_W-1:0] qber_thresh,
    output logic                accept
);

    logic [QBER_PROD_W-1:0] w_err_prod;
    logic [QBER_PROD_W-1:0] w_lim_prod;

    assign w_err_prod = QBER_PROD_W'(err_count)  * QBER_PROD_W'(PCT_SCALE);
    assign w_lim_prod = QBER_PROD_W'(sift_count) * QBER_PROD_W'(qber_thresh);
    assign accept     = (w_err_prod <= w_lim_prod);

endmodule : qkd_qber_cmp
`default_nettype wire

// File: rtl/qkd_sift_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : qkd_sift_round_ctrl
//  Purpose  : Sequences one QKD sifting round: clears the sifting core,
//             requests raw pulses until target_len sifted bits are stored,
//             evaluates QBER, and on acceptance walks the readout addresses
//             0..sift_count-1 out through a valid/ready handshake.
//  Ports    : clk, rst_n (sync, active-low)
//             start, stop, target_len, qber_thresh      round control
//             sift_we, sift_err                          from sifting core
//             sift_valid, sift_clr_n                     to sifting core
//             rd_valid, rd_addr, rd_ready                readout handshake
//             busy, round_done, accept, abort, cfg_err   status
//             sift_count, err_count, raw_count           live counters
//  Config   : SIFT_TIMEOUT_EN - when defined, RAW_LIMIT raw pulses in RUN end
//             the round with a timeout, which always aborts.
//  Revision : 1.0  initial release
// ============================================================================
module qkd_sift_round_ctrl
    import qkd_sift_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int RAW_W     = 16,
    parameter int RAW_LIMIT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   target_len,
    input  logic [THRESH_W-1:0] qber_thresh,
    input  logic                sift_we,
    input  logic                sift_err,
    input  logic                rd_ready,
    output logic                sift_valid,
    output logic                sift_clr_n,
    output logic                rd_valid,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                busy,
    output logic                round_done,
    output logic                accept,
    output logic                abort,
    output logic                cfg_err,
    output logic [ADDR_W-1:0]   sift_count,
    output logic [ADDR_W-1:0]   err_count,
    output logic [RAW_W-1:0]    raw_count
);

    sift_state_e         r_state;
    logic                r_busy, r_sift_valid, r_sift_clr_n, r_rd_valid;
    logic                r_round_done, r_accept, r_abort, r_cfg_err, r_timeout;
    logic [ADDR_W-1:0]   r_rd_addr, r_sift_count, r_err_count, r_target_len;
    logic [RAW_W-1:0]    r_raw_count;
    logic [THRESH_W-1:0] r_qber_thresh;

    logic w_qber_ok;
    logic w_target_hit;
    logic w_limit_hit;

    // The bit stored this cycle completes the round when it brings the count
    // to target_len; sift_count < target_len always holds inside RUN.
    assign w_target_hit = sift_we && ((r_sift_count + ADDR_W'(1)) == r_target_len);

`ifdef SIFT_TIMEOUT_EN
    localparam logic [RAW_W:0] c_RAW_LIMIT = (RAW_W+1)'(RAW_LIMIT);
    // Fires on the RUN cycle whose increment makes raw_count reach the limit.
    assign w_limit_hit = (({1'b0, r_raw_count} + (RAW_W+1)'(1)) >= c_RAW_LIMIT);
`else
    assign w_limit_hit = 1'b0;
`endif

    qkd_qber_cmp #(
        .ADDR_W      (ADDR_W)
    ) u_qber_cmp (
        .sift_count  (r_sift_count),
        .err_count   (r_err_count),
        .qber_thresh (r_qber_thresh),
        .accept      (w_qber_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_sift_valid  <= 1'b0;
            r_sift_clr_n  <= 1'b1;
            r_rd_valid    <= 1'b0;
            r_rd_addr     <= '0;
            r_round_done  <= 1'b0;
            r_accept      <= 1'b0;
            r_abort       <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_timeout     <= 1'b0;
            r_sift_count  <= '0;
            r_err_count   <= '0;
            r_raw_count   <= '0;
            r_target_len  <= '0;
            r_qber_thresh <= '0;
        end else begin
            // One-cycle pulses default low; the state that owns them raises them.
            r_sift_clr_n <= 1'b1;
            r_round_done <= 1'b0;
            r_abort      <= 1'b0;
            r_cfg_err    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (target_len != '0) begin
                            r_state       <= S_CLEAR;
                            r_busy        <= 1'b1;
                            r_sift_clr_n  <= 1'b0;
                            r_target_len  <= target_len;
                            r_qber_thresh <= qber_thresh;
                            r_sift_count  <= '0;
                            r_err_count   <= '0;
                            r_raw_count   <= '0;
                            r_rd_addr     <= '0;
                            r_accept      <= 1'b0;
                            r_timeout     <= 1'b0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    r_state      <= S_RUN;
                    r_sift_valid <= 1'b1;
                end

                S_RUN: begin
                    if (r_raw_count != '1) begin
                        r_raw_count <= r_raw_count + RAW_W'(1);
                    end
                    if (sift_we && (r_sift_count != '1)) begin
                        r_sift_count <= r_sift_count + ADDR_W'(1);
                    end
                    if (sift_we && sift_err && (r_err_count != '1)) begin
                        r_err_count <= r_err_count + ADDR_W'(1);
                    end
                    if (stop) begin
                        r_state      <= S_ABORT;
                        r_sift_valid <= 1'b0;
                        r_abort      <= 1'b1;
                        r_round_done <= 1'b1;
                        r_accept     <= 1'b0;
                    end else if (w_target_hit || w_limit_hit) begin
                        r_state      <= S_EVAL;
                        r_sift_valid <= 1'b0;
                        r_timeout    <= w_limit_hit;
                    end
                end

                S_EVAL: begin
                    if (!stop && w_qber_ok && !r_timeout) begin
                        r_state    <= S_READOUT;
                        r_accept   <= 1'b1;
                        r_rd_valid <= 1'b1;
                        r_rd_addr  <= '0;
                    end else begin
                        r_state      <= S_ABORT;
                        r_abort      <= 1'b1;
                        r_round_done <= 1'b1;
                        r_accept     <= 1'b0;
                    end
                end

                S_READOUT: begin
                    if (stop) begin
                        r_state      <= S_ABORT;
                        r_rd_valid   <= 1'b0;
                        r_abort      <= 1'b1;
                        r_round_done <= 1'b1;
                        r_accept     <= 1'b0;
                    end else if (rd_ready) begin
                        if (r_rd_addr == (r_sift_count - ADDR_W'(1))) begin
                            r_state      <= S_FINISH;
                            r_rd_valid   <= 1'b0;
                            r_round_done <= 1'b1;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        end
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                S_ABORT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_sift_valid <= 1'b0;
                    r_rd_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign sift_valid = r_sift_valid;
    assign sift_clr_n = r_sift_clr_n;
    assign rd_valid   = r_rd_valid;
    assign rd_addr    = r_rd_addr;
    assign busy       = r_busy;
    assign round_done = r_round_done;
    assign accept     = r_accept;
    assign abort      = r_abort;
    assign cfg_err    = r_cfg_err;
    assign sift_count = r_sift_count;
    assign err_count  = r_err_count;
    assign raw_count  = r_raw_count;

endmodule : qkd_sift_round_ctrl
`default_nettype wire

// File: doc/qkd_sift_round_ctrl.md
QKD_SIFT_ROUND_CTRL -- requirements
Module: qkd_sift_round_ctrl

Interface
REQ-001 Parameter ADDR_W, 10: width of sifted-key count and readout address.
REQ-002 Parameter RAW_W, 16: width of raw-pulse counter.
REQ-003 Parameter RAW_LIMIT, 4096: raw pulses per round before timeout (SIFT_TIMEOUT_EN only).
REQ-004 Port clk  in  1: single clock, all logic rising-edge.
REQ-005 Port rst_n  in  1: synchronous, active-low reset.
REQ-006 Port start  in  1: one-cycle round-start request.
REQ-007 Port stop  in  1: operator abort request.
REQ-008 Port target_len  in  ADDR_W: sifted bits wanted per round, sampled on accepted start.
REQ-009 Port qber_thresh  in  7: QBER acceptance limit in percent (0..100), sampled on accepted start.
REQ-010 Port sift_we  in  1: sifting core stored one sifted bit this cycle.
REQ-011 Port sift_err  in  1: stored bit pair mismatched; qualified by sift_we.
REQ-012 Port rd_ready  in  1: downstream consumer accepts readout address.
REQ-013 Port sift_valid  out  1: raw-pulse request level to sifting core.
REQ-014 Port sift_clr_n  out  1: active-low one-cycle clear to sifting core.
REQ-015 Port rd_valid / rd_addr  out  1 / ADDR_W: readout handshake to consumer.
REQ-016 Port busy, round_done, accept, abort, cfg_err  out  1 each: status; round_done, abort, cfg_err are one-cycle pulses.
REQ-017 Port sift_count / err_count  out  ADDR_W; raw_count  out  RAW_W: live round counters.

Function
REQ-018 States SHALL be IDLE, CLEAR, RUN, EVAL, READOUT, FINISH, ABORT; busy=1 in all except IDLE.
REQ-019 IDLE: start with target_len!=0 SHALL go to CLEAR; start with target_len==0 SHALL pulse cfg_err and stay in IDLE.
REQ-020 CLEAR: sift_clr_n=0 for exactly this cycle, all counters zeroed, accept cleared; next state RUN.
REQ-021 RUN: sift_valid=1; raw_count +1 per cycle; sift_we increments sift_count; sift_we&&sift_err increments err_count.
REQ-022 RUN: when sift_count+sift_we equals target_len, that bit SHALL be counted and next state EVAL; sift_valid=0 from EVAL on.
REQ-023 sift_we/sift_err outside RUN SHALL be ignored.
REQ-024 EVAL (one cycle): accept iff err_count*100 <= sift_count*qber_thresh, both products 17-bit unsigned, no timeout; accept -> READOUT with accept=1, else ABORT.
REQ-025 READOUT: rd_valid=1, rd_addr starts at 0 and increments on rd_valid&&rd_ready; handshake at rd_addr==sift_count-1 -> FINISH.
REQ-026 FINISH: round_done pulse, accept held until next CLEAR; -> IDLE.
REQ-027 ABORT: abort and round_done pulse together, accept=0; -> IDLE.
REQ-028 stop in RUN, EVAL or READOUT SHALL go to ABORT next cycle; stop wins over simultaneous target reach or final handshake.
REQ-029 start while busy SHALL be ignored; counters saturate, never wrap.

Reset
REQ-030 rst_n=0 at a clock edge: state IDLE, sift_clr_n=1, all other outputs 0, counters 0, from any state incl. mid-round.

Configuration
REQ-031 SIFT_TIMEOUT_EN defined: raw_count reaching RAW_LIMIT in RUN SHALL go to EVAL with timeout set, forcing ABORT.
REQ-032 SIFT_TIMEOUT_EN undefined: no timeout logic, RAW_LIMIT unused, raw_count saturates at all-ones.

Structure
REQ-033 Shared package qkd_sift_pkg SHALL hold the state enum, ADDR_W default and PCT_SCALE=100.
REQ-034 QBER compare SHALL be a sub-module qkd_qber_cmp (counts, threshold -> accept bit), combinational.

Verification
REQ-035 target_len=8, thresh=10, 8 sift_we no err -> EVAL, accept=1, rd_addr 0..7, round_done once.
REQ-036 target_len=10, thresh=10, 2 errors of 10 -> 200>100, abort and round_done pulse, rd_valid never high.
REQ-037 target_len=10, thresh=10, 1 error -> 100<=100, accept=1 (boundary).
REQ-038 start with target_len=0 -> cfg_err one cycle, busy stays 0.
REQ-039 stop same cycle as 8th sift_we -> ABORT, accept=0; rd_ready low 3 cycles in READOUT -> rd_addr held.
REQ-040 SIFT_TIMEOUT_EN, RAW_LIMIT=16, no sift_we -> abort after 16 RUN cycles; rst_n low mid-RUN -> all outputs reset next edge.
